fp_rs: RTL and testbench

Reservation station for the floating-point execution unit. It sits between the issue stage and the FPU. It buffers up to RS_DEPTH issued instructions and captures missing operands from the common data bus (CDB). It dispatches operand-complete entries to the FPU and holds returned results until the CDB accepts them.

---
 rtl/fp_rs.sv | 215 +++++++++++++++++++++
 tb/tb_fp_rs.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_rs.sv
// Floating-point reservation station: buffers issued ops, snoops the CDB for
// missing operands, dispatches to the FPU and holds results until broadcast.
package len5_pkg;
  localparam int XLEN = 64;

  typedef enum logic [4:0] {
    E_INSTR_ADDR_MISALIGNED = 5'h00,
    E_INSTR_ACCESS_FAULT    = 5'h01,
    E_ILLEGAL_INSTRUCTION   = 5'h02,
    E_BREAKPOINT            = 5'h03,
    E_LD_ADDR_MISALIGNED    = 5'h04,
    E_LD_ACCESS_FAULT       = 5'h05,
    E_ST_ADDR_MISALIGNED    = 5'h06,
    E_ST_ACCESS_FAULT       = 5'h07,
    E_UNKNOWN               = 5'h1f
  } except_code_t;
endpackage

module fp_rs
  import len5_pkg::*;
#(
  parameter int RS_DEPTH    = 4,
  parameter int EU_CTL_LEN  = 4,
  parameter int ROB_IDX_LEN = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic                          issue_valid_i,
  output logic                          issue_ready_o,
  input  logic [EU_CTL_LEN-1:0]         issue_eu_ctl_i,
  input  logic                          issue_rs1_ready_i,
  input  logic [ROB_IDX_LEN-1:0]        issue_rs1_idx_i,
  input  logic [XLEN-1:0]               issue_rs1_value_i,
  input  logic                          issue_rs2_ready_i,
  input  logic [ROB_IDX_LEN-1:0]        issue_rs2_idx_i,
  input  logic [XLEN-1:0]               issue_rs2_value_i,
  input  logic [ROB_IDX_LEN-1:0]        issue_dest_idx_i,
  input  logic                          cdb_valid_i,
  input  logic [ROB_IDX_LEN-1:0]        cdb_idx_i,
  input  logic [XLEN-1:0]               cdb_value_i,
  output logic                          eu_valid_o,
  input  logic                          eu_ready_i,
  output logic [EU_CTL_LEN-1:0]         eu_ctl_o,
  output logic [XLEN-1:0]               eu_rs1_o,
  output logic [XLEN-1:0]               eu_rs2_o,
  output logic [$clog2(RS_DEPTH)-1:0]   eu_entry_idx_o,
  input  logic                          eu_valid_i,
  output logic                          eu_ready_o,
  input  logic [$clog2(RS_DEPTH)-1:0]   eu_entry_idx_i,
  input  logic [XLEN-1:0]               eu_result_i,
  input  logic                          eu_except_raised_i,
  input  except_code_t                  eu_except_code_i,
  output logic                          cdb_req_o,
  input  logic                          cdb_ready_i,
  output logic [ROB_IDX_LEN-1:0]        cdb_idx_o,
  output logic [XLEN-1:0]               cdb_value_o,
  output logic                          cdb_except_raised_o,
  output except_code_t                  cdb_except_code_o
);

  localparam int IDX_W = $clog2(RS_DEPTH);

  typedef enum logic [2:0] {
    S_EMPTY    = 3'd0,
    S_WAIT_OPS = 3'd1,
    S_READY    = 3'd2,
    S_EXEC     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  typedef struct packed {
    state_t                   state;
    logic [EU_CTL_LEN-1:0]    ctl;
    logic [ROB_IDX_LEN-1:0]   dest;
    logic                     rs1_rdy;
    logic [ROB_IDX_LEN-1:0]   rs1_idx;
    logic [XLEN-1:0]          rs1_val;
    logic                     rs2_rdy;
    logic [ROB_IDX_LEN-1:0]   rs2_idx;
    logic [XLEN-1:0]          rs2_val;
    logic [XLEN-1:0]          result;
    logic                     except_raised;
    except_code_t             except_code;
  } entry_t;

  entry_t              entries [RS_DEPTH];
  logic [RS_DEPTH-1:0] empty_vec;
  logic [RS_DEPTH-1:0] ready_vec;
  logic [RS_DEPTH-1:0] done_vec;
  logic [IDX_W-1:0]    issue_idx;
  logic [IDX_W-1:0]    disp_idx;
  logic [IDX_W-1:0]    wb_idx;
  logic                issue_fire;
  logic                eu_fire;
  logic                wb_fire;

  // Operands broadcast on the CDB in the issue cycle are captured directly.
  logic                issue_rs1_fwd;
  logic                issue_rs2_fwd;
  logic                issue_rs1_rdy;
  logic                issue_rs2_rdy;
  logic [XLEN-1:0]     issue_rs1_val;
  logic [XLEN-1:0]     issue_rs2_val;

  assign issue_rs1_fwd = !issue_rs1_ready_i && cdb_valid_i && (issue_rs1_idx_i == cdb_idx_i);
  assign issue_rs2_fwd = !issue_rs2_ready_i && cdb_valid_i && (issue_rs2_idx_i == cdb_idx_i);
  assign issue_rs1_rdy = issue_rs1_ready_i || issue_rs1_fwd;
  assign issue_rs2_rdy = issue_rs2_ready_i || issue_rs2_fwd;
  assign issue_rs1_val = issue_rs1_fwd ? cdb_value_i : issue_rs1_value_i;
  assign issue_rs2_val = issue_rs2_fwd ? cdb_value_i : issue_rs2_value_i;

  // Lowest-index selection for issue, dispatch and writeback.
  always_comb begin
    issue_idx = '0;
    disp_idx  = '0;
    wb_idx    = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (empty_vec[i]) issue_idx = IDX_W'(i);
      if (ready_vec[i]) disp_idx  = IDX_W'(i);
      if (done_vec[i])  wb_idx    = IDX_W'(i);
    end
  end

  assign issue_ready_o = |empty_vec;
  assign eu_valid_o    = |ready_vec;
  assign cdb_req_o     = |done_vec;
  assign eu_ready_o    = 1'b1;
  assign issue_fire    = issue_valid_i && issue_ready_o;
  assign eu_fire       = eu_valid_o && eu_ready_i;
  assign wb_fire       = cdb_req_o && cdb_ready_i;

  generate
    for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_entry
      entry_t entry_reg;
      entry_t entry_next;
      logic   rs1_hit;
      logic   rs2_hit;

      assign rs1_hit = !entry_reg.rs1_rdy && cdb_valid_i && (entry_reg.rs1_idx == cdb_idx_i);
      assign rs2_hit = !entry_reg.rs2_rdy && cdb_valid_i && (entry_reg.rs2_idx == cdb_idx_i);

      always_comb begin
        entry_next = entry_reg;
        case (entry_reg.state)
          S_EMPTY: begin
            if (issue_fire && (issue_idx == IDX_W'(gi))) begin
              entry_next.ctl           = issue_eu_ctl_i;
              entry_next.dest          = issue_dest_idx_i;
              entry_next.rs1_rdy       = issue_rs1_rdy;
              entry_next.rs1_idx       = issue_rs1_idx_i;
              entry_next.rs1_val       = issue_rs1_val;
              entry_next.rs2_rdy       = issue_rs2_rdy;
              entry_next.rs2_idx       = issue_rs2_idx_i;
              entry_next.rs2_val       = issue_rs2_val;
              entry_next.result        = '0;
              entry_next.except_raised = 1'b0;
              entry_next.except_code   = E_UNKNOWN;
              entry_next.state         = (issue_rs1_rdy && issue_rs2_rdy) ? S_READY : S_WAIT_OPS;
            end
          end
          S_WAIT_OPS: begin
            if (rs1_hit) begin
              entry_next.rs1_rdy = 1'b1;
              entry_next.rs1_val = cdb_value_i;
            end
            if (rs2_hit) begin
              entry_next.rs2_rdy = 1'b1;
              entry_next.rs2_val = cdb_value_i;
            end
            if ((entry_reg.rs1_rdy || rs1_hit) && (entry_reg.rs2_rdy || rs2_hit))
              entry_next.state = S_READY;
          end
          S_READY: begin
            if (eu_fire && (disp_idx == IDX_W'(gi))) entry_next.state = S_EXEC;
          end
          S_EXEC: begin
            if (eu_valid_i && (eu_entry_idx_i == IDX_W'(gi))) begin
              entry_next.result        = eu_result_i;
              entry_next.except_raised = eu_except_raised_i;
              entry_next.except_code   = eu_except_code_i;
              entry_next.state         = S_DONE;
            end
          end
          S_DONE: begin
            if (wb_fire && (wb_idx == IDX_W'(gi))) entry_next.state = S_EMPTY;
          end
          default: entry_next.state = S_EMPTY;
        endcase
        if (flush_i) entry_next.state = S_EMPTY;
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) entry_reg <= '0;
        else          entry_reg <= entry_next;
      end

      assign empty_vec[gi] = (entry_reg.state == S_EMPTY);
      assign ready_vec[gi] = (entry_reg.state == S_READY);
      assign done_vec[gi]  = (entry_reg.state == S_DONE);
      assign entries[gi]   = entry_reg;
    end
  endgenerate

  // Data outputs read as zero / E_UNKNOWN whenever their valid is low.
  assign eu_ctl_o            = eu_valid_o ? entries[disp_idx].ctl     : '0;
  assign eu_rs1_o            = eu_valid_o ? entries[disp_idx].rs1_val : '0;
  assign eu_rs2_o            = eu_valid_o ? entries[disp_idx].rs2_val : '0;
  assign eu_entry_idx_o      = disp_idx;
  assign cdb_idx_o           = cdb_req_o ? entries[wb_idx].dest          : '0;
  assign cdb_value_o         = cdb_req_o ? entries[wb_idx].result        : '0;
  assign cdb_except_raised_o = cdb_req_o ? entries[wb_idx].except_raised : 1'b0;
  assign cdb_except_code_o   = cdb_req_o ? entries[wb_idx].except_code   : E_UNKNOWN;

endmodule

// File: tb/tb_fp_rs.sv
// Directed bench for fp_rs with dispatch and writeback scoreboards.
module tb_fp_rs;
  import len5_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_n_i;
  logic                flush_i;
  logic                issue_valid_i;
  logic                issue_ready_o;
  logic [3:0]          issue_eu_ctl_i;
  logic                issue_rs1_ready_i;
  logic [3:0]          issue_rs1_idx_i;
  logic [63:0]         issue_rs1_value_i;
  logic                issue_rs2_ready_i;
  logic [3:0]          issue_rs2_idx_i;
  logic [63:0]         issue_rs2_value_i;
  logic [3:0]          issue_dest_idx_i;
  logic                cdb_valid_i;
  logic [3:0]          cdb_idx_i;
  logic [63:0]         cdb_value_i;
  logic                eu_valid_o;
  logic                eu_ready_i;
  logic [3:0]          eu_ctl_o;
  logic [63:0]         eu_rs1_o;
  logic [63:0]         eu_rs2_o;
  logic [1:0]          eu_entry_idx_o;
  logic                eu_valid_i;
  logic                eu_ready_o;
  logic [1:0]          eu_entry_idx_i;
  logic [63:0]         eu_result_i;
  logic                eu_except_raised_i;
  except_code_t        eu_except_code_i;
  logic                cdb_req_o;
  logic                cdb_ready_i;
  logic [3:0]          cdb_idx_o;
  logic [63:0]         cdb_value_o;
  logic                cdb_except_raised_o;
  except_code_t        cdb_except_code_o;

  fp_rs #(.RS_DEPTH(4), .EU_CTL_LEN(4), .ROB_IDX_LEN(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_eu_ctl_i(issue_eu_ctl_i),
    .issue_rs1_ready_i(issue_rs1_ready_i), .issue_rs1_idx_i(issue_rs1_idx_i),
    .issue_rs1_value_i(issue_rs1_value_i),
    .issue_rs2_ready_i(issue_rs2_ready_i), .issue_rs2_idx_i(issue_rs2_idx_i),
    .issue_rs2_value_i(issue_rs2_value_i),
    .issue_dest_idx_i(issue_dest_idx_i),
    .cdb_valid_i(cdb_valid_i), .cdb_idx_i(cdb_idx_i), .cdb_value_i(cdb_value_i),
    .eu_valid_o(eu_valid_o), .eu_ready_i(eu_ready_i), .eu_ctl_o(eu_ctl_o),
    .eu_rs1_o(eu_rs1_o), .eu_rs2_o(eu_rs2_o), .eu_entry_idx_o(eu_entry_idx_o),
    .eu_valid_i(eu_valid_i), .eu_ready_o(eu_ready_o), .eu_entry_idx_i(eu_entry_idx_i),
    .eu_result_i(eu_result_i), .eu_except_raised_i(eu_except_raised_i),
    .eu_except_code_i(eu_except_code_i),
    .cdb_req_o(cdb_req_o), .cdb_ready_i(cdb_ready_i), .cdb_idx_o(cdb_idx_o),
    .cdb_value_o(cdb_value_o), .cdb_except_raised_o(cdb_except_raised_o),
    .cdb_except_code_o(cdb_except_code_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  ctl;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [1:0]  idx;
  } disp_t;

  typedef struct {
    logic [3:0]   dest;
    logic [63:0]  val;
    logic         exc;
    except_code_t code;
  } wb_t;

  disp_t disp_q[$];
  wb_t   wb_q[$];
  int    n_pass  = 0;
  int    n_fail  = 0;
  int    n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_disp(input logic [3:0] ctl, input logic [63:0] rs1,
                          input logic [63:0] rs2, input logic [1:0] idx);
    disp_t d;
    d.ctl = ctl; d.rs1 = rs1; d.rs2 = rs2; d.idx = idx;
    disp_q.push_back(d);
  endtask

  // Compares any handshake happening in the current cycle against the queues.
  task automatic monitor();
    disp_t d;
    wb_t   w;
    if (eu_valid_o && eu_ready_i) begin
      chk("disp_expected", 64'(disp_q.size() != 0), 64'd1);
      if (disp_q.size() != 0) begin
        d = disp_q.pop_front();
        $display("dispatch entry=%0d ctl=%0h rs1=%0h rs2=%0h", eu_entry_idx_o, eu_ctl_o, eu_rs1_o, eu_rs2_o);
        chk("disp_ctl", 64'(eu_ctl_o), 64'(d.ctl));
        chk("disp_rs1", eu_rs1_o, d.rs1);
        chk("disp_rs2", eu_rs2_o, d.rs2);
        chk("disp_idx", 64'(eu_entry_idx_o), 64'(d.idx));
      end
    end
    if (cdb_req_o && cdb_ready_i) begin
      chk("wb_expected", 64'(wb_q.size() != 0), 64'd1);
      if (wb_q.size() != 0) begin
        w = wb_q.pop_front();
        $display("writeback tag=%0d value=%0h exc=%0b code=%0h", cdb_idx_o, cdb_value_o, cdb_except_raised_o, cdb_except_code_o);
        chk("wb_tag", 64'(cdb_idx_o), 64'(w.dest));
        chk("wb_value", cdb_value_o, w.val);
        chk("wb_exc", 64'(cdb_except_raised_o), 64'(w.exc));
        chk("wb_code", 64'(cdb_except_code_o), 64'(w.code));
      end
    end
  endtask

  task automatic step();
    #1;
    monitor();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear();
    issue_valid_i = 1'b0;
    cdb_valid_i   = 1'b0;
    eu_valid_i    = 1'b0;
    flush_i       = 1'b0;
  endtask

  task automatic issue(input logic [3:0] ctl, input logic r1, input logic [3:0] t1,
                       input logic [63:0] v1, input logic r2, input logic [3:0] t2,
                       input logic [63:0] v2, input logic [3:0] dest);
    issue_valid_i = 1'b1; issue_eu_ctl_i = ctl; issue_dest_idx_i = dest;
    issue_rs1_ready_i = r1; issue_rs1_idx_i = t1; issue_rs1_value_i = v1;
    issue_rs2_ready_i = r2; issue_rs2_idx_i = t2; issue_rs2_value_i = v2;
  endtask

  task automatic eu_res(input logic [1:0] idx, input logic [63:0] val, input logic exc,
                        input except_code_t code, input logic [3:0] dest, input bit push);
    wb_t w;
    eu_valid_i = 1'b1; eu_entry_idx_i = idx; eu_result_i = val;
    eu_except_raised_i = exc; eu_except_code_i = code;
    if (push) begin
      w.dest = dest; w.val = val; w.exc = exc; w.code = code;
      wb_q.push_back(w);
    end
  endtask

  task automatic cdb_bcast(input logic [3:0] tag, input logic [63:0] val);
    cdb_valid_i = 1'b1; cdb_idx_i = tag; cdb_value_i = val;
  endtask

  logic [3:0] dests [4];

  initial begin
    dests = '{4'd10, 4'd11, 4'd9, 4'd12};
    rst_n_i = 1'b0;
    clear();
    issue_eu_ctl_i = '0; issue_dest_idx_i = '0;
    issue_rs1_ready_i = 1'b0; issue_rs1_idx_i = '0; issue_rs1_value_i = '0;
    issue_rs2_ready_i = 1'b0; issue_rs2_idx_i = '0; issue_rs2_value_i = '0;
    cdb_idx_i = '0; cdb_value_i = '0;
    eu_entry_idx_i = '0; eu_result_i = '0; eu_except_raised_i = 1'b0;
    eu_except_code_i = E_UNKNOWN;
    eu_ready_i = 1'b1; cdb_ready_i = 1'b1;

    // Reset values
    #3;
    chk("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    chk("rst_eu_ready", 64'(eu_ready_o), 64'd1);
    chk("rst_eu_valid", 64'(eu_valid_o), 64'd0);
    chk("rst_cdb_req", 64'(cdb_req_o), 64'd0);
    chk("rst_eu_rs1", eu_rs1_o, 64'd0);
    chk("rst_eu_entry_idx", 64'(eu_entry_idx_o), 64'd0);
    chk("rst_cdb_value", cdb_value_o, 64'd0);
    chk("rst_cdb_code", 64'(cdb_except_code_o), 64'(E_UNKNOWN));
    @(negedge clk_i) rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Both operands ready: dispatch in cycle 1, writeback after result
    issue(4'd3, 1'b1, 4'd0, 64'd10, 1'b1, 4'd0, 64'd2, 4'd1);
    exp_disp(4'd3, 64'd10, 64'd2, 2'd0);
    step(); clear();
    chk("t1_eu_valid_c1", 64'(eu_valid_o), 64'd1);
    step();
    chk("t1_exec_no_valid", 64'(eu_valid_o), 64'd0);
    eu_res(2'd0, 64'h55, 1'b0, E_UNKNOWN, 4'd1, 1'b1);
    step(); clear();
    chk("t1_cdb_req", 64'(cdb_req_o), 64'd1);
    step();
    chk("t1_cdb_req_clr", 64'(cdb_req_o), 64'd0);

    // rs2 woken by CDB two cycles after issue
    issue(4'd5, 1'b1, 4'd0, 64'd3, 1'b0, 4'd5, 64'd0, 4'd2);
    exp_disp(4'd5, 64'd3, 64'd7, 2'd0);
    step(); clear();
    chk("t2_wait_c1", 64'(eu_valid_o), 64'd0);
    step();
    cdb_bcast(4'd5, 64'd7);
    chk("t2_wait_c2", 64'(eu_valid_o), 64'd0);
    step(); clear();
    chk("t2_woken_valid", 64'(eu_valid_o), 64'd1);
    chk("t2_woken_rs2", eu_rs2_o, 64'd7);
    step();
    eu_res(2'd0, 64'h77, 1'b0, E_UNKNOWN, 4'd2, 1'b1);
    step(); clear();
    step();

    // Same-cycle CDB forwarding at issue
    issue(4'd6, 1'b0, 4'd6, 64'd0, 1'b1, 4'd0, 64'd4, 4'd3);
    cdb_bcast(4'd6, 64'h11);
    exp_disp(4'd6, 64'h11, 64'd4, 2'd0);
    step(); clear();
    chk("t2b_fwd_valid", 64'(eu_valid_o), 64'd1);
    step();
    eu_res(2'd0, 64'h88, 1'b1, E_BREAKPOINT, 4'd3, 1'b1);
    step(); clear();
    step();

    // Fill all entries while the FPU stalls
    eu_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(4'(i), 1'b1, 4'd0, 64'(100 + i), 1'b1, 4'd0, 64'(200 + i), dests[i]);
      exp_disp(4'(i), 64'(100 + i), 64'(200 + i), 2'(i));
      step();
    end
    clear();
    chk("t3_full", 64'(issue_ready_o), 64'd0);
    issue(4'd15, 1'b1, 4'd0, 64'd999, 1'b1, 4'd0, 64'd999, 4'd15);
    step(); clear();
    chk("t3_full_hold", 64'(issue_ready_o), 64'd0);
    chk("t3_stall_rs1", eu_rs1_o, 64'd100);
    chk("t3_stall_idx", 64'(eu_entry_idx_o), 64'd0);
    eu_ready_i = 1'b1;
    repeat (4) step();
    chk("t3_drained", 64'(eu_valid_o), 64'd0);
    chk("t3_disp_q_empty", 64'(disp_q.size()), 64'd0);

    // Result with exception held by CDB back-pressure
    cdb_ready_i = 1'b0;
    eu_res(2'd2, 64'h40, 1'b1, E_ILLEGAL_INSTRUCTION, 4'd9, 1'b1);
    step(); clear();
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_req", 64'(cdb_req_o), 64'd1);
      chk("t4_hold_tag", 64'(cdb_idx_o), 64'd9);
      chk("t4_hold_value", cdb_value_o, 64'h40);
      chk("t4_hold_code", 64'(cdb_except_code_o), 64'(E_ILLEGAL_INSTRUCTION));
      step();
    end
    cdb_ready_i = 1'b1;
    step();
    chk("t4_freed_req", 64'(cdb_req_o), 64'd0);
    chk("t4_freed_issue_ready", 64'(issue_ready_o), 64'd1);

    // Flush with entries in DONE, EXEC and WAIT_OPS
    cdb_ready_i = 1'b0;
    eu_res(2'd0, 64'h99, 1'b0, E_UNKNOWN, 4'd10, 1'b0);
    issue(4'd7, 1'b0, 4'd7, 64'd0, 1'b1, 4'd0, 64'd1, 4'd14);
    step(); clear();
    chk("t5_pre_cdb_req", 64'(cdb_req_o), 64'd1);
    chk("t5_pre_full", 64'(issue_ready_o), 64'd0);
    flush_i = 1'b1;
    step(); clear();
    chk("t5_flush_issue_ready", 64'(issue_ready_o), 64'd1);
    chk("t5_flush_eu_valid", 64'(eu_valid_o), 64'd0);
    chk("t5_flush_cdb_req", 64'(cdb_req_o), 64'd0);
    cdb_ready_i = 1'b1;
    eu_res(2'd1, 64'hAA, 1'b0, E_UNKNOWN, 4'd11, 1'b0);
    cdb_bcast(4'd7, 64'h5);
    step(); clear();
    chk("t5_stale_result_dropped", 64'(cdb_req_o), 64'd0);
    chk("t5_no_wakeup", 64'(eu_valid_o), 64'd0);

    // Asynchronous reset mid-operation
    eu_ready_i = 1'b0;
    issue(4'd1, 1'b1, 4'd0, 64'h123, 1'b1, 4'd0, 64'h456, 4'd5);
    step(); clear();
    chk("t6_pre_valid", 64'(eu_valid_o), 64'd1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("t6_rst_eu_valid", 64'(eu_valid_o), 64'd0);
    chk("t6_rst_issue_ready", 64'(issue_ready_o), 64'd1);
    chk("t6_rst_eu_rs1", eu_rs1_o, 64'd0);
    chk("t6_rst_cdb_code", 64'(cdb_except_code_o), 64'(E_UNKNOWN));
    @(negedge clk_i) rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    eu_ready_i = 1'b1;
    issue(4'd2, 1'b1, 4'd0, 64'h21, 1'b1, 4'd0, 64'h22, 4'd6);
    exp_disp(4'd2, 64'h21, 64'h22, 2'd0);
    step(); clear();
    step();
    eu_res(2'd0, 64'h2222, 1'b0, E_UNKNOWN, 4'd6, 1'b1);
    step(); clear();
    step();
    chk("end_disp_q_empty", 64'(disp_q.size()), 64'd0);
    chk("end_wb_q_empty", 64'(wb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
